// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared state encoding and 7-segment pattern table for the scan controller
package seg_scan_pkg;
  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // Entry v holds the gfedcba pattern for value v; 10-15 are dark.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// bcd_seg7_dec: combinational BCD to active-high 7-segment pattern lookup
module bcd_seg7_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[bcd_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with dead-time, frame-synchronous data update and leading-zero blanking
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           active_q, active_d;
  logic [BW-1:0]           shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;
  logic                    slot_end, frame_end, drive, zero_run;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   lz_blank;

  // Slot counter and digit index; disabling the scan parks both at their reset values.
  always_comb begin
    slot_end  = cnt_q == CNT_LAST;
    frame_end = en && slot_end && idx_q == IDX_LAST;
    cnt_d     = (!en || slot_end) ? '0 : cnt_q + CW'(1);
    idx_d     = !en ? '0 : !slot_end ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // Slot FSM: dark dead-time first, then drive the selected digit until the slot wraps.
  always_comb begin
    state_d = state_q;
    state_d = !en ? S_BLANK
            : (state_q == S_BLANK) ? ((cnt_q == BLANK_LAST) ? S_DRIVE : S_BLANK)
            : (slot_end ? S_BLANK : S_DRIVE);
  end

  // Shadow capture runs regardless of en; the active copy only changes at a frame boundary,
  // where a coincident load bypasses the shadow so the newest value is never lost.
  always_comb begin
    shadow_d  = load ? bcd_in : shadow_q;
    pending_d = frame_end ? 1'b0 : (load | pending_q);
    active_d  = !frame_end ? active_q : load ? bcd_in : pending_q ? shadow_q : active_q;
  end

  // Select the next digit to show and flag digits that are part of a leading-zero run.
  always_comb begin
    cur_digit = 4'h0;
    lz_blank  = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (active_d[4*i +: 4] == 4'h0);
      lz_blank[i] = (i != 0) && zero_run;
      if (IW'(i) == idx_d) cur_digit = active_d[4*i +: 4];
    end
  end

  bcd_seg7_dec u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Pin values are computed from next state so the registered outputs track the FSM exactly.
  always_comb begin
    drive = state_d == S_DRIVE;
    seg_d = (drive && !(lz_en && lz_blank[idx_d])) ? dec_seg : SEG_BLANK;
    an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = !(drive && IW'(i) == idx_d);
    fd_d  = en && cnt_d == CNT_LAST && idx_d == IDX_LAST;
  end

  // State, data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 dark cycles)
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, en, load, lz_en;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  int          n_cmp = 0;
  int          n_err = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks {an,seg,frame_done} for n cycles starting at slot 0 cycle 0; p[s] is the pattern expected in slot s.
  task automatic run(input string tag, input logic [3:0][6:0] p, input int n,
                     input int load_at, input logic [15:0] val, input int off_at);
    logic [3:0] ea;
    logic [6:0] es;
    int s, c;
    for (int k = 0; k < n; k++) begin
      s  = k / 8;
      c  = k % 8;
      ea = (c < 2) ? 4'hF : ~(4'b0001 << s);
      es = (c < 2) ? 7'h00 : p[s];
      chk($sformatf("%s k%0d", tag, k), {an, seg, frame_done}, {ea, es, k == 31});
      if (k == load_at) begin
        load   = 1'b1;
        bcd_in = val;
      end
      if (k == off_at) en = 1'b0;
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; lz_en = 1'b0; bcd_in = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset", {an, seg, frame_done}, {4'hF, 7'h00, 1'b0});
    rst_n = 1'b1; en = 1'b1;
    run("f0_0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 32, 0, 16'h1234, -1);
    run("f1_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 32, 10, 16'h0042, -1);
    lz_en = 1'b1;
    run("f2_0042_lz", {7'h00, 7'h00, 7'h66, 7'h5B}, 32, 31, 16'h5678, -1);
    chk("pend_after_boundary_load", {11'h0, dut.pending_q}, 12'h0);
    run("f3_5678", {7'h6D, 7'h7D, 7'h07, 7'h7F}, 32, 5, 16'h00A0, -1);
    lz_en = 1'b0;
    run("f4_00a0", {7'h3F, 7'h3F, 7'h00, 7'h3F}, 32, -1, 16'h0, -1);
    run("f5_partial", {7'h3F, 7'h3F, 7'h00, 7'h3F}, 20, -1, 16'h0, 19);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("en_off d%0d", d), {an, seg, frame_done}, {4'hF, 7'h00, 1'b0});
      @(negedge clk);
    end
    en = 1'b1;
    run("f6_restart", {7'h3F, 7'h3F, 7'h00, 7'h3F}, 32, -1, 16'h0, -1);
    run("f7_partial", {7'h3F, 7'h3F, 7'h00, 7'h3F}, 12, 3, 16'h9999, -1);
    chk("pend_set", {11'h0, dut.pending_q}, 12'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {an, seg, frame_done}, {4'hF, 7'h00, 1'b0});
    chk("pend_rst", {11'h0, dut.pending_q}, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("f8_0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 32, -1, 16'h0, -1);
    run("f9_0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 32, -1, 16'h0, -1);
    lz_en = 1'b1;
    run("f10_0000_lz", {7'h00, 7'h00, 7'h00, 7'h3F}, 32, -1, 16'h0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits, legal range 2..8.
REQ-002 Parameter SLOT_CYCLES, default 50000: clock cycles per digit slot, minimum BLANK_CYCLES+1.
REQ-003 Parameter BLANK_CYCLES, default 64: anti-ghosting dead time at the start of each slot, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  scan enable; 0 = display dark, scan held.
REQ-007 load  input  1  single-cycle strobe to capture bcd_in.
REQ-008 bcd_in  input  4*NUM_DIGITS  packed BCD, digit 0 (least significant) in bits [3:0].
REQ-009 lz_en  input  1  leading-zero blanking enable, sampled every cycle.
REQ-010 seg  output  7  active-high segments, bit 0 = a through bit 6 = g.
REQ-011 an  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
REQ-012 frame_done  output  1  one-cycle pulse at the end of the last digit slot.

Function
REQ-013 FSM states: S_BLANK (an all 1, seg 0) for BLANK_CYCLES cycles, then S_DRIVE (an[idx]=0, seg=decode of digit idx) for SLOT_CYCLES-BLANK_CYCLES cycles, then S_BLANK for the next idx.
REQ-014 Slot counter counts 0..SLOT_CYCLES-1 and wraps; idx advances on wrap, going from NUM_DIGITS-1 to 0.
REQ-015 seg, an and frame_done are registered outputs loaded from next-state logic, so pin values match the current state with no decode glitches.
REQ-016 load captures bcd_in into a shadow register and sets pending; active digits change only at the frame boundary (idx wrap to 0), so no frame ever mixes old and new digits.
REQ-017 At the frame boundary, pending data is copied to the active register and pending is cleared; frame_done is 1 in the last cycle of slot NUM_DIGITS-1.
REQ-018 load in the same cycle as the frame boundary: bcd_in goes straight to the active register and pending ends at 0.
REQ-019 Repeated load before a boundary: the last captured value wins.
REQ-020 Decode: values 0-9 give standard patterns (0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F); values 10-15 give 7'h00 (blank), an still asserted.
REQ-021 Leading-zero blanking: when lz_en=1, digit i>0 gives seg=0 if it and all higher active digits are 0; digit 0 is never blanked.
REQ-022 en=0: next cycle an all 1, seg 0, frame_done 0; counter, idx and state are forced to reset values; load and the shadow still operate.
REQ-023 en 0 to 1 restarts at idx 0, S_BLANK, counter 0; pending data transfers at the first frame boundary after restart.

Reset
REQ-024 rst_n low: asynchronous reset to state S_BLANK, counter 0, idx 0, active and shadow all 0, pending 0, an all 1, seg 0, frame_done 0.
REQ-025 Reset mid-slot or mid-frame discards pending data; the first slot after release is S_BLANK for idx 0.

Structure
REQ-026 Package seg_scan_pkg holds the state enum (S_BLANK, S_DRIVE), the SEG_BLANK constant 7'h00 and the 16-entry digit-pattern constant table.
REQ-027 One sub-module bcd_seg7_dec (4-bit in, 7-bit out, combinational, per REQ-020) is instantiated once and time-shared across digits.
REQ-028 Counter width is $clog2(SLOT_CYCLES) and idx width is $clog2(NUM_DIGITS); no other arithmetic is used.

Verification (bench parameters NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-029 Reset release, en=1, load bcd_in=16'h1234 -> after the next boundary, slots show an=1110/seg=7'h66, 1101/7'h4F, 1011/7'h5B, 0111/7'h06; each slot is 2 dark cycles + 6 driven cycles; frame_done every 32 cycles.
REQ-030 load 16'h0042 during slot idx=1 -> current frame unchanged; next frame shows 42 on digits 0-1; with lz_en=1, digits 2-3 have seg=0 while their an bit is low.
REQ-031 load 16'h5678 in the exact frame_done cycle -> the immediately following frame shows 5678; pending reads 0.
REQ-032 Digit value 4'hA loaded -> seg=7'h00 in its slot; the an bit is still low.
REQ-033 en dropped mid-S_DRIVE of idx=2 -> next cycle an=1111, seg=0; en raised -> restart at idx 0 with 2 dark cycles.
REQ-034 rst_n pulsed low mid-frame with pending set -> outputs immediately reset asynchronously; after release the display shows 0000 and the pending value is lost.
